// File: rtl/sync_gen_pkg.sv
// Shared types and helpers for the sync_gen periodic sync-pulse generator.
// Holds the FSM state encoding and the period-counter width function.
package sync_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // Bits needed to hold PERIOD-1, at least one.
  function automatic int ctr_width(input int period);
    int w;
    w = 1;
    while ((1 << w) < period) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_period_ctr.sv
// Period down-counter for sync_gen: reload to PERIOD-1, decrement, zero flag.
// Saturates at zero so it never wraps below 0.
module sync_period_ctr
  import sync_gen_pkg::*;
#(
  parameter int PERIOD = 1024,
  parameter int W      = ctr_width(PERIOD)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

  logic [W-1:0] r_count;
  logic         w_zero;

  assign w_zero = (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_dec && !w_zero) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = w_zero;

endmodule

// File: rtl/sync_gen.sv
// Periodic sync-pulse generator locked to an external reference sync.
// Define SYNC_GEN_CHECK_EN to flag and resync on misaligned ext_sync in RUN.
module sync_gen
  import sync_gen_pkg::*;
#(
  parameter int PERIOD     = 1024,
  parameter int COUNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  arm,
  input  logic                  ext_sync,
  output logic                  sync_out,
  output logic                  armed,
  output logic                  running,
  output logic                  period_err,
  output logic [COUNT_BITS-1:0] sync_count
);

  localparam int CW = ctr_width(PERIOD);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync_out;
  logic                  r_armed;
  logic                  r_running;
  logic [COUNT_BITS-1:0] r_count;
  logic                  w_load;
  logic                  w_dec;
  logic                  w_fire;
  logic                  w_zero;
  logic [CW-1:0]         w_ctr;
`ifdef SYNC_GEN_CHECK_EN
  logic                  r_err;
  logic                  w_err_set;
  logic                  w_err_clr;
`endif

  sync_period_ctr #(
    .PERIOD (PERIOD),
    .W      (CW)
  ) u_ctr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .o_count (w_ctr),
    .o_zero  (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_fire      = 1'b0;
`ifdef SYNC_GEN_CHECK_EN
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
`endif
    if (ce) begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (arm) w_state_nxt = S_ARMED;
        end
        (r_state == S_ARMED): begin
          if (!arm && ext_sync) begin
            w_state_nxt = S_RUN;
            w_load      = 1'b1;
            w_fire      = 1'b1;
          end
        end
        (r_state == S_RUN): begin
          // arm wins over ext_sync and freezes the counter
          if (arm) begin
            w_state_nxt = S_ARMED;
`ifdef SYNC_GEN_CHECK_EN
            w_err_clr   = 1'b1;
          end else if (ext_sync) begin
            w_load      = 1'b1;
            w_fire      = 1'b1;
            w_err_set   = !w_zero;
`endif
          end else if (w_zero) begin
            w_load      = 1'b1;
            w_fire      = 1'b1;
          end else begin
            w_dec       = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync_out <= 1'b0;
      r_armed    <= 1'b0;
      r_running  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_out <= w_fire;
      r_armed    <= (w_state_nxt == S_ARMED);
      r_running  <= (w_state_nxt == S_RUN);
      if (w_fire) r_count <= r_count + COUNT_BITS'(1);
    end
  end

`ifdef SYNC_GEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign period_err = r_err;
`else
  assign period_err = 1'b0;
`endif

  assign sync_out   = r_sync_out;
  assign armed      = r_armed;
  assign running    = r_running;
  assign sync_count = r_count;

endmodule

// File: tb/tb_sync_gen.sv
// Self-checking bench for sync_gen (PERIOD=8, COUNT_BITS=4).
// Scoreboard of per-cycle expected outputs plus scenario pulse-time checks.
module tb_sync_gen;

  localparam int P  = 8;
  localparam int CB = 4;
`ifdef SYNC_GEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic          arm = 1'b0;
  logic          ext_sync = 1'b0;
  logic          sync_out;
  logic          armed;
  logic          running;
  logic          period_err;
  logic [CB-1:0] sync_count;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int pulses[$];
  int pcnt[$];
  logic [7:0] exp_q[$];

  int m_st = 0;
  int m_ctr = 0;
  int m_pe = 0;
  int m_cnt = 0;

  sync_gen #(
    .PERIOD     (P),
    .COUNT_BITS (CB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .arm        (arm),
    .ext_sync   (ext_sync),
    .sync_out   (sync_out),
    .armed      (armed),
    .running    (running),
    .period_err (period_err),
    .sync_count (sync_count)
  );

  always #5 clk = ~clk;

  function automatic string qstr(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  // Reference behaviour: states 0 idle, 1 armed, 2 run.
  task automatic model_step(input logic r, c, a, e);
    int so;
    so = 0;
    if (r) begin
      m_st = 0; m_ctr = 0; m_pe = 0; m_cnt = 0;
    end else if (c) begin
      if (a) begin
        if (m_st == 2) m_pe = 0;
        m_st = 1;
      end else if (m_st == 1 && e) begin
        m_st = 2; m_ctr = P - 1; so = 1;
      end else if (m_st == 2) begin
        if (CHK && e) begin
          if (m_ctr != 0) m_pe = 1;
          m_ctr = P - 1; so = 1;
        end else if (m_ctr == 0) begin
          m_ctr = P - 1; so = 1;
        end else begin
          m_ctr = m_ctr - 1;
        end
      end
    end
    m_cnt = (m_cnt + so) % (1 << CB);
    exp_q.push_back({so[0], m_st == 1, m_st == 2, m_pe[0], m_cnt[3:0]});
  endtask

  task automatic cyc(input logic r, c, a, e);
    logic [7:0] got, ex;
    rst = r; ce = c; arm = a; ext_sync = e;
    model_step(r, c, a, e);
    @(posedge clk);
    #1;
    got = {sync_out, armed, running, period_err, sync_count};
    ex = exp_q.pop_front();
    checks++;
    if (got !== ex) begin
      failures++;
      $display("FAIL scoreboard t=%0d got=%b exp=%b", t + 1, got, ex);
    end
    if (sync_out === 1'b1) begin
      pulses.push_back(t + 1);
      pcnt.push_back(int'(sync_count));
    end
    t++;
  endtask

  task automatic start();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    pulses.delete();
    pcnt.delete();
    t = 0;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({sync_out, armed, running, period_err, sync_count} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {sync_out, armed, running, period_err, sync_count});
    end
  endtask

  task automatic test_periodic();
    string s;
    start();
    for (int i = 0; i <= 20; i++) cyc(1'b0, 1'b1, i == 0, i == 3);
    s = qstr(pulses);
    checks++;
    if (s != "4 12 20 ") begin
      failures++;
      $display("FAIL periodic_pulses got=%s exp=4 12 20", s);
    end
    checks++;
    if (sync_count !== 4'd3) begin
      failures++;
      $display("FAIL periodic_count got=%0d exp=3", sync_count);
    end
  endtask

  task automatic test_rst_mid_run();
    string s;
    start();
    for (int i = 0; i <= 25; i++) begin
      cyc(i == 20, 1'b1, i == 0, i == 3 || i == 22);
      if (i == 20) begin
        checks++;
        if ({sync_out, armed, running, period_err, sync_count} !== 8'h00) begin
          failures++;
          $display("FAIL rst_mid_run got=%b exp=00000000",
                   {sync_out, armed, running, period_err, sync_count});
        end
      end
    end
    s = qstr(pulses);
    checks++;
    if (s != "4 12 20 ") begin
      failures++;
      $display("FAIL rst_mid_run_pulses got=%s exp=4 12 20", s);
    end
  endtask

  task automatic test_ce_toggle();
    string s;
    start();
    for (int i = 0; i <= 22; i++)
      cyc(1'b0, (i < 4) || (i % 2 == 0), i == 0, i == 3);
    s = qstr(pulses);
    checks++;
    if (s != "4 19 ") begin
      failures++;
      $display("FAIL ce_toggle_pulses got=%s exp=4 19", s);
    end
  endtask

  task automatic test_arm_priority();
    string s, es;
    start();
    for (int i = 0; i <= 12; i++) begin
      cyc(1'b0, 1'b1, i == 0 || i == 5, i == 3 || i == 4 || i == 5 || i == 9);
      if (i == 5) begin
        checks++;
        if ({sync_out, armed, running, period_err} !== 4'b0100) begin
          failures++;
          $display("FAIL arm_priority got=%b exp=0100",
                   {sync_out, armed, running, period_err});
        end
      end
    end
    es = CHK ? "4 5 10 " : "4 10 ";
    s = qstr(pulses);
    checks++;
    if (s != es) begin
      failures++;
      $display("FAIL arm_priority_pulses got=%s exp=%s", s, es);
    end
  endtask

  task automatic test_check();
    string s, es;
    start();
    for (int i = 0; i <= 18; i++) begin
      cyc(1'b0, 1'b1, i == 0, i == 3 || i == 8);
      if (i == 8) begin
        checks++;
        if (period_err !== CHK) begin
          failures++;
          $display("FAIL check_err got=%b exp=%b", period_err, CHK);
        end
      end
    end
    es = CHK ? "4 9 17 " : "4 12 ";
    s = qstr(pulses);
    checks++;
    if (s != es) begin
      failures++;
      $display("FAIL check_pulses got=%s exp=%s", s, es);
    end
    start();
    for (int i = 0; i <= 13; i++) cyc(1'b0, 1'b1, i == 0, i == 3 || i == 11);
    s = qstr(pulses);
    checks++;
    if (s != "4 12 " || period_err !== 1'b0) begin
      failures++;
      $display("FAIL check_aligned got=%s err=%b exp=4 12 err=0", s, period_err);
    end
  endtask

  task automatic test_wrap();
    string s;
    start();
    for (int i = 0; i <= 132; i++) cyc(1'b0, 1'b1, i == 0, i == 3);
    s = qstr(pcnt);
    checks++;
    if (s != "1 2 3 4 5 6 7 8 9 10 11 12 13 14 15 0 1 ") begin
      failures++;
      $display("FAIL wrap_counts got=%s exp=1..15 0 1", s);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_rst_mid_run();
    test_ce_toggle();
    test_arm_priority();
    test_check();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
